// File: rtl/sky130_ef_io__gpio_cfg_seq_if.sv
// Core-side bus of the gpio configuration sequencer: shadow-write handshake,
// apply request and sequence status.
interface sky130_ef_io__gpio_cfg_seq_if #(
    parameter int NPADS = 8
);
    localparam int IW = (NPADS > 1) ? $clog2(NPADS) : 1;

    logic              CFG_VALID;
    logic              CFG_READY;
    logic [IW-1:0]     CFG_IDX;
    logic [11:0]       CFG_WORD;
    logic              APPLY;
    logic [NPADS-1:0]  APPLY_MASK;
    logic              BUSY;
    logic              DONE;
    logic              CFG_ERR;

    modport master (
        output CFG_VALID, CFG_IDX, CFG_WORD, APPLY, APPLY_MASK,
        input  CFG_READY, BUSY, DONE, CFG_ERR
    );

    modport slave (
        input  CFG_VALID, CFG_IDX, CFG_WORD, APPLY, APPLY_MASK,
        output CFG_READY, BUSY, DONE, CFG_ERR
    );
endinterface

// File: rtl/sky130_ef_io__gpio_cfg_seq.sv
// Shadow/active control-word store for NPADS gpiov2 pads with a glitch-free
// hold -> update -> settle apply sequence.
module sky130_ef_io__gpio_cfg_seq #(
    parameter int          NPADS       = 8,
    parameter int          HOLD_CYC    = 4,
    parameter logic [11:0] DEFAULT_CFG = 12'h019
) (
    input  logic                      CLK,
    input  logic                      RST,
    sky130_ef_io__gpio_cfg_seq_if.slave cfg,
    output logic [12*NPADS-1:0]       PAD_CFG,
    output logic [NPADS-1:0]          HLD_H_N
);
    localparam int IW = (NPADS > 1) ? $clog2(NPADS) : 1;
    localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, HOLD, UPDATE, SETTLE} state_t;

    state_t                 state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [NPADS-1:0]       mask;
    logic [NPADS-1:0][11:0] shadow;
    logic [NPADS-1:0][11:0] active;
    logic [NPADS-1:0]       hld;
    logic                   done;
    logic                   err;
    logic                   ready;
    logic [NPADS-1:0]       wr_sel;
    logic                   wr_bad;

    assign ready = (state == IDLE);

    // Decode the write index; an index that matches no pad is an error.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NPADS; i++)
            wr_sel[i] = cfg.CFG_VALID && ready && (cfg.CFG_IDX == IW'(i));
        wr_bad = cfg.CFG_VALID && ready && !(|wr_sel);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (cfg.APPLY && |cfg.APPLY_MASK) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt == CNT_LAST) begin
                    state_d = UPDATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            UPDATE: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow <= {NPADS{DEFAULT_CFG}};
            active <= {NPADS{DEFAULT_CFG}};
            hld    <= '0;
            mask   <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            for (int i = 0; i < NPADS; i++)
                if (wr_sel[i]) shadow[i] <= cfg.CFG_WORD;
            if (wr_bad) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg.APPLY) begin
                        if (|cfg.APPLY_MASK) begin
                            mask <= cfg.APPLY_MASK;
                            hld  <= hld & ~cfg.APPLY_MASK;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    // Same-edge writes already landed in shadow before this point.
                    for (int i = 0; i < NPADS; i++)
                        if (mask[i]) active[i] <= shadow[i];
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        hld  <= hld | mask;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PAD_CFG       = active;
    assign HLD_H_N       = hld;
    assign cfg.CFG_READY = ready;
    assign cfg.BUSY      = (state != IDLE);
    assign cfg.DONE      = done;
    assign cfg.CFG_ERR   = err;
endmodule

// File: tb/tb_sky130_ef_io__gpio_cfg_seq.sv
// Directed bench: NPADS=4/HOLD_CYC=3 main instance with a DONE-driven
// scoreboard, plus an NPADS=3 instance for out-of-range index handling.
module tb_sky130_ef_io__gpio_cfg_seq;
    localparam int          HC  = 3;
    localparam logic [11:0] DEF = 12'h019;

    typedef struct packed {
        logic [47:0] pad;
        logic [3:0]  hld;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sky130_ef_io__gpio_cfg_seq_if #(.NPADS(4)) bus4 ();
    sky130_ef_io__gpio_cfg_seq_if #(.NPADS(3)) bus3 ();

    logic [47:0] pad4;
    logic [3:0]  hld4;
    logic [35:0] pad3;
    logic [2:0]  hld3;

    sky130_ef_io__gpio_cfg_seq #(.NPADS(4), .HOLD_CYC(HC), .DEFAULT_CFG(DEF)) dut4 (
        .CLK(CLK), .RST(RST), .cfg(bus4.slave), .PAD_CFG(pad4), .HLD_H_N(hld4)
    );
    sky130_ef_io__gpio_cfg_seq #(.NPADS(3), .HOLD_CYC(HC), .DEFAULT_CFG(DEF)) dut3 (
        .CLK(CLK), .RST(RST), .cfg(bus3.slave), .PAD_CFG(pad3), .HLD_H_N(hld3)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic [11:0] m_sh [4];
    logic [11:0] m_act[4];
    logic [3:0]  m_hld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [47:0] pack_act();
        logic [47:0] p;
        for (int i = 0; i < 4; i++) p[12*i +: 12] = m_act[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = DEF;
            m_act[i] = DEF;
        end
        m_hld = 4'b0000;
        sb.delete();
    endtask

    task automatic wr4(input logic [1:0] idx, input logic [11:0] word);
        bus4.CFG_VALID = 1'b1;
        bus4.CFG_IDX   = idx;
        bus4.CFG_WORD  = word;
        m_sh[idx]      = word;
        step();
        bus4.CFG_VALID = 1'b0;
    endtask

    // Model the result of an accepted apply and queue it for the DONE monitor.
    task automatic push_apply(input logic [3:0] mask);
        exp_t e;
        for (int i = 0; i < 4; i++) if (mask[i]) m_act[i] = m_sh[i];
        m_hld = m_hld | mask;
        e.pad = pack_act();
        e.hld = m_hld;
        sb.push_back(e);
    endtask

    // Full apply sequence on dut4 with per-cycle checks t+1..t+9;
    // extra=1 fires a second APPLY at t+3 that must be ignored.
    task automatic apply_seq(input string tag, input logic [3:0] mask, input bit extra);
        logic [47:0] prev_pad, exp_pad;
        logic [3:0]  prev_hld;
        prev_pad        = pack_act();
        prev_hld        = m_hld;
        bus4.APPLY      = 1'b1;
        bus4.APPLY_MASK = mask;
        push_apply(mask);
        exp_pad = pack_act();
        step();
        bus4.APPLY      = 1'b0;
        bus4.APPLY_MASK = 4'b0000;
        bus4.CFG_VALID  = 1'b0;
        for (int c = 1; c <= 2*HC + 2; c++) begin
            chk({tag, "_unmasked_hld"}, hld4 & ~mask, prev_hld & ~mask);
            if (c <= 2*HC + 1) begin
                chk({tag, "_held"}, hld4 & mask, 4'b0000);
                chk({tag, "_busy"}, bus4.BUSY, 1'b1);
                chk({tag, "_ready_low"}, bus4.CFG_READY, 1'b0);
            end
            if (c == HC + 1) chk({tag, "_pad_before"}, pad4, prev_pad);
            if (c == HC + 2) chk({tag, "_pad_update"}, pad4, exp_pad);
            if (c == 2*HC + 2) begin
                chk({tag, "_done"}, bus4.DONE, 1'b1);
                chk({tag, "_busy_end"}, bus4.BUSY, 1'b0);
                chk({tag, "_hld_end"}, hld4, m_hld);
                chk({tag, "_pad_end"}, pad4, exp_pad);
            end
            if (extra && c == 3) begin
                bus4.APPLY      = 1'b1;
                bus4.APPLY_MASK = 4'b0001;
            end else begin
                bus4.APPLY      = 1'b0;
                bus4.APPLY_MASK = 4'b0000;
            end
            if (c < 2*HC + 2) step();
        end
        step();
        chk({tag, "_idle_after"}, {bus4.BUSY, bus4.DONE}, 2'b00);
    endtask

    // Scoreboard: every DONE pulse on dut4 must match a queued expectation.
    always @(negedge CLK) begin
        if (!RST && bus4.DONE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_spurious_done", 64'(bus4.DONE), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pad", pad4, e.pad);
                chk("sb_hld", hld4, e.hld);
            end
        end
    end

    initial begin
        bus4.CFG_VALID = 1'b0; bus4.CFG_IDX = '0; bus4.CFG_WORD = '0;
        bus4.APPLY = 1'b0; bus4.APPLY_MASK = '0;
        bus3.CFG_VALID = 1'b0; bus3.CFG_IDX = '0; bus3.CFG_WORD = '0;
        bus3.APPLY = 1'b0; bus3.APPLY_MASK = '0;
        model_reset();
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        step();

        // Reset state
        chk("rst_pad4", pad4, {4{DEF}});
        chk("rst_hld4", hld4, 4'b0000);
        chk("rst_status4", {bus4.BUSY, bus4.DONE, bus4.CFG_READY, bus4.CFG_ERR}, 4'b0010);
        chk("rst_pad3", pad3, {3{DEF}});
        chk("rst_hld3", hld3, 3'b000);

        // Single pad apply
        wr4(2'd2, 12'h2A6);
        apply_seq("single", 4'b0100, 1'b0);
        chk("single_others", {pad4[47:36], pad4[23:0]}, {DEF, DEF, DEF});

        // All pads, with an ignored APPLY while busy
        wr4(2'd0, 12'h101);
        wr4(2'd1, 12'h3C2);
        wr4(2'd2, 12'h0A4);
        wr4(2'd3, 12'h7E8);
        apply_seq("all", 4'b1111, 1'b1);

        // Same-edge write and apply: the apply must pick up the new word
        bus4.CFG_VALID = 1'b1;
        bus4.CFG_IDX   = 2'd1;
        bus4.CFG_WORD  = 12'h0F0;
        m_sh[1]        = 12'h0F0;
        apply_seq("same_edge", 4'b0010, 1'b0);
        chk("same_edge_slice", pad4[23:12], 12'h0F0);

        // Out-of-range index on a 3-pad instance
        bus3.CFG_VALID = 1'b1;
        bus3.CFG_IDX   = 2'd3;
        bus3.CFG_WORD  = 12'hFFF;
        step();
        bus3.CFG_VALID = 1'b0;
        chk("err_set", bus3.CFG_ERR, 1'b1);
        step(); step();
        chk("err_sticky", bus3.CFG_ERR, 1'b1);
        bus3.APPLY      = 1'b1;
        bus3.APPLY_MASK = 3'b000;
        step();
        bus3.APPLY = 1'b0;
        chk("mask0_done", {bus3.DONE, bus3.BUSY}, 2'b10);
        step();
        chk("mask0_after", {bus3.DONE, bus3.BUSY}, 2'b00);
        bus3.APPLY      = 1'b1;
        bus3.APPLY_MASK = 3'b111;
        step();
        bus3.APPLY      = 1'b0;
        bus3.APPLY_MASK = 3'b000;
        for (int c = 2; c <= 2*HC + 2; c++) step();
        chk("err_apply_done", bus3.DONE, 1'b1);
        chk("err_no_shadow_change", pad3, {3{DEF}});
        chk("err_hld3", hld3, 3'b111);
        chk("err_still_set", bus3.CFG_ERR, 1'b1);

        // Reset in the middle of a sequence
        wr4(2'd3, 12'h5A5);
        bus4.APPLY      = 1'b1;
        bus4.APPLY_MASK = 4'b1000;
        step();
        bus4.APPLY      = 1'b0;
        bus4.APPLY_MASK = 4'b0000;
        step(); step(); step();
        RST = 1'b1;
        step();
        model_reset();
        chk("midrst_pad4", pad4, {4{DEF}});
        chk("midrst_hld4", hld4, 4'b0000);
        chk("midrst_status", {bus4.BUSY, bus4.DONE, bus4.CFG_READY}, 3'b001);
        chk("midrst_err3", bus3.CFG_ERR, 1'b0);
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("midrst_no_done", bus4.DONE, 1'b0);
        end
        chk("midrst_pad_stable", pad4, {4{DEF}});

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
